// File: rtl/float_types_pkg.sv
// Shared floating-point operand type and requester tag type for the FP add arbiter.
package float_types_pkg;

  typedef logic [31:0] float_point_num;
  typedef logic        fpu_req_tag_t;

  localparam int unsigned FPU_REQ_NUM = 2;

endpackage

// File: rtl/fpu_tag_fifo.sv
// In-order requester-tag FIFO; a pop while empty with a concurrent push returns the pushed tag.
module fpu_tag_fifo
  import float_types_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fpu_req_tag_t push_tag_i,
  input  logic         pop_i,
  output fpu_req_tag_t pop_tag_c_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fpu_req_tag_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             bypass, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

  always_comb begin
    bypass      = empty_o && push_i && pop_i;
    do_push     = push_i && !bypass && (!full_o || pop_i);
    do_pop      = pop_i && !empty_o;
    pop_tag_c_o = empty_o ? push_tag_i : mem_q[rd_ptr_q];
    wr_ptr_d    = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_tag_i;
    end
  end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Two-requester round-robin front end for a shared in-order FP add pipeline with per-requester credits.
module fpu_add_arbiter
  import float_types_pkg::*;
#(
  parameter int unsigned MAX_OUT = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           req0_valid_i,
  output logic           req0_ready_o,
  input  float_point_num req0_a_i,
  input  float_point_num req0_b_i,
  input  logic           req1_valid_i,
  output logic           req1_ready_o,
  input  float_point_num req1_a_i,
  input  float_point_num req1_b_i,
  output logic           fpu_valid_o,
  output float_point_num fpu_a_o,
  output float_point_num fpu_b_o,
  input  logic           fpu_valid_i,
  input  float_point_num fpu_res_i,
  output logic           rsp0_valid_o,
  output float_point_num rsp0_res_o,
  output logic           rsp1_valid_o,
  output float_point_num rsp1_res_o,
  output logic           err_o
);

  localparam int unsigned DEPTH = 2 * MAX_OUT;
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  logic [FPU_REQ_NUM-1:0] req_valid, eligible, grant;
  float_point_num         req_a [FPU_REQ_NUM];
  float_point_num         req_b [FPU_REQ_NUM];
  logic [CNT_W-1:0]       out_q [FPU_REQ_NUM];
  logic [CNT_W-1:0]       out_d [FPU_REQ_NUM];
  fpu_req_tag_t           prio_q, prio_d, push_tag, pop_tag;
  logic                   handshake, tag_avail, fifo_empty, fifo_full;
  logic                   fpu_valid_q, fpu_valid_d;
  float_point_num         fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
  logic [FPU_REQ_NUM-1:0] rsp_valid_q, rsp_valid_d;
  float_point_num         rsp_res_q [FPU_REQ_NUM];
  float_point_num         rsp_res_d [FPU_REQ_NUM];
  logic                   err_q, err_d;

  // Credit-qualified grant; on a tie the requester not granted last wins.
  always_comb begin
    req_valid = {req1_valid_i, req0_valid_i};
    req_a[0]  = req0_a_i;
    req_a[1]  = req1_a_i;
    req_b[0]  = req0_b_i;
    req_b[1]  = req1_b_i;
    for (int n = 0; n < int'(FPU_REQ_NUM); n++) begin
      eligible[n] = req_valid[n] && (out_q[n] < CNT_W'(MAX_OUT)) && !fifo_full && !rst_i;
    end
    grant = eligible;
    if (&eligible) begin
      grant         = '0;
      grant[prio_q] = 1'b1;
    end
  end

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];
  assign handshake    = |grant;
  assign push_tag     = fpu_req_tag_t'(grant[1]);
  assign tag_avail    = !fifo_empty || handshake;

  fpu_tag_fifo #(
    .DEPTH(DEPTH)
  ) u_tag_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (handshake),
    .push_tag_i  (push_tag),
    .pop_i       (fpu_valid_i),
    .pop_tag_c_o (pop_tag),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  always_comb begin
    prio_d      = prio_q;
    fpu_valid_d = handshake;
    fpu_a_d     = fpu_a_q;
    fpu_b_d     = fpu_b_q;
    rsp_valid_d = '0;
    rsp_res_d   = rsp_res_q;
    err_d       = err_q;
    if (handshake) begin
      prio_d  = ~push_tag;
      fpu_a_d = req_a[push_tag];
      fpu_b_d = req_b[push_tag];
    end
    // A result with no tag to route is dropped and flagged until reset.
    if (fpu_valid_i) begin
      if (tag_avail) begin
        rsp_valid_d[pop_tag] = 1'b1;
        rsp_res_d[pop_tag]   = fpu_res_i;
      end else begin
        err_d = 1'b1;
      end
    end
    for (int n = 0; n < int'(FPU_REQ_NUM); n++) begin
      out_d[n] = out_q[n] + CNT_W'(grant[n]) - CNT_W'(rsp_valid_q[n]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q      <= '0;
      fpu_valid_q <= 1'b0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      rsp_valid_q <= '0;
      err_q       <= 1'b0;
      for (int n = 0; n < int'(FPU_REQ_NUM); n++) begin
        out_q[n]     <= '0;
        rsp_res_q[n] <= '0;
      end
    end else begin
      prio_q      <= prio_d;
      fpu_valid_q <= fpu_valid_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      for (int n = 0; n < int'(FPU_REQ_NUM); n++) begin
        out_q[n]     <= out_d[n];
        rsp_res_q[n] <= rsp_res_d[n];
      end
    end
  end

  assign fpu_valid_o  = fpu_valid_q;
  assign fpu_a_o      = fpu_a_q;
  assign fpu_b_o      = fpu_b_q;
  assign rsp0_valid_o = rsp_valid_q[0];
  assign rsp1_valid_o = rsp_valid_q[1];
  assign rsp0_res_o   = rsp_res_q[0];
  assign rsp1_res_o   = rsp_res_q[1];
  assign err_o        = err_q;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Directed and randomised bench for fpu_add_arbiter, checked against a queue-based reference model.
module tb_fpu_add_arbiter;
  import float_types_pkg::*;

  localparam int MAX_OUT = 4;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           req0_valid_i, req1_valid_i;
  logic           req0_ready_o, req1_ready_o;
  float_point_num req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic           fpu_valid_o;
  float_point_num fpu_a_o, fpu_b_o;
  logic           fpu_valid_i;
  float_point_num fpu_res_i;
  logic           rsp0_valid_o, rsp1_valid_o;
  float_point_num rsp0_res_o, rsp1_res_o;
  logic           err_o;

  always #5 clk_i = ~clk_i;

  fpu_add_arbiter #(.MAX_OUT(MAX_OUT)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_a_i     (req0_a_i),
    .req0_b_i     (req0_b_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_a_i     (req1_a_i),
    .req1_b_i     (req1_b_i),
    .fpu_valid_o  (fpu_valid_o),
    .fpu_a_o      (fpu_a_o),
    .fpu_b_o      (fpu_b_o),
    .fpu_valid_i  (fpu_valid_i),
    .fpu_res_i    (fpu_res_i),
    .rsp0_valid_o (rsp0_valid_o),
    .rsp0_res_o   (rsp0_res_o),
    .rsp1_valid_o (rsp1_valid_o),
    .rsp1_res_o   (rsp1_res_o),
    .err_o        (err_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: credits, tie priority and an in-order queue of pending requester ids.
  int             out_n [2];
  int             prio;
  int             tagq [$];
  bit             m_fv;
  float_point_num m_a, m_b;
  bit             m_rsp [2];
  float_point_num m_res [2];
  bit             m_err;

  // External pipeline: fixed latency, in order.
  typedef struct {
    int             due;
    float_point_num res;
  } pipe_t;
  pipe_t pipeq [$];

  int             cyc, lat;
  bit             auto_pipe, chk_on;
  bit             s_r0, s_r1, s_fv, s_rsp0, s_rsp1, s_err;
  float_point_num s_res0, s_res1;
  int             rsp_seen [2];

  task automatic model_reset();
    out_n[0] = 0; out_n[1] = 0;
    prio = 0;
    tagq.delete();
    m_fv = 0; m_a = '0; m_b = '0;
    m_rsp[0] = 0; m_rsp[1] = 0;
    m_res[0] = '0; m_res[1] = '0;
    m_err = 0;
  endtask

  // One clock cycle: inputs already applied; sample and check at the falling edge, then advance the model.
  task automatic cycle();
    int    g, t;
    bit    e0, e1;
    bit    n_rsp [2];
    pipe_t p;
    if (auto_pipe && pipeq.size() > 0 && pipeq[0].due <= cyc) begin
      p = pipeq.pop_front();
      fpu_valid_i = 1'b1;
      fpu_res_i   = p.res;
    end
    @(negedge clk_i);
    e0 = req0_valid_i && !rst_i && (out_n[0] < MAX_OUT);
    e1 = req1_valid_i && !rst_i && (out_n[1] < MAX_OUT);
    g = -1;
    if (e0 && e1) g = prio;
    else if (e0)  g = 0;
    else if (e1)  g = 1;
    s_r0 = req0_ready_o; s_r1 = req1_ready_o; s_fv = fpu_valid_o;
    s_rsp0 = rsp0_valid_o; s_rsp1 = rsp1_valid_o; s_err = err_o;
    s_res0 = rsp0_res_o; s_res1 = rsp1_res_o;
    rsp_seen[0] += int'(s_rsp0);
    rsp_seen[1] += int'(s_rsp1);
    if (chk_on) begin
      check_eq("req0_ready", 32'(req0_ready_o), 32'(g == 0));
      check_eq("req1_ready", 32'(req1_ready_o), 32'(g == 1));
      check_eq("fpu_valid", 32'(fpu_valid_o), 32'(m_fv));
      check_eq("fpu_a", fpu_a_o, m_a);
      check_eq("fpu_b", fpu_b_o, m_b);
      check_eq("rsp0_valid", 32'(rsp0_valid_o), 32'(m_rsp[0]));
      check_eq("rsp1_valid", 32'(rsp1_valid_o), 32'(m_rsp[1]));
      check_eq("rsp0_res", rsp0_res_o, m_res[0]);
      check_eq("rsp1_res", rsp1_res_o, m_res[1]);
      check_eq("err", 32'(err_o), 32'(m_err));
    end
    if (fpu_valid_o) begin
      p.due = cyc + lat;
      p.res = float_point_num'($urandom());
      pipeq.push_back(p);
    end
    if (rst_i) begin
      model_reset();
    end else begin
      out_n[0] -= int'(m_rsp[0]);
      out_n[1] -= int'(m_rsp[1]);
      n_rsp[0] = 0; n_rsp[1] = 0;
      m_fv = (g >= 0);
      if (g >= 0) begin
        out_n[g]++;
        tagq.push_back(g);
        prio = 1 - g;
        m_a = (g == 1) ? req1_a_i : req0_a_i;
        m_b = (g == 1) ? req1_b_i : req0_b_i;
      end
      if (fpu_valid_i) begin
        if (tagq.size() > 0) begin
          t = tagq.pop_front();
          n_rsp[t] = 1;
          m_res[t] = fpu_res_i;
        end else begin
          m_err = 1;
        end
      end
      m_rsp = n_rsp;
    end
    @(posedge clk_i);
    #1;
    cyc++;
    fpu_valid_i = 1'b0;
  endtask

  task automatic do_reset(input bit keep_pipe);
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    fpu_valid_i  = 1'b0;
    rst_i        = 1'b1;
    cycle();
    rst_i = 1'b0;
    if (!keep_pipe) pipeq.delete();
  endtask

  task automatic rand_ops();
    req0_a_i = float_point_num'($urandom());
    req0_b_i = float_point_num'($urandom());
    req1_a_i = float_point_num'($urandom());
    req1_b_i = float_point_num'($urandom());
  endtask

  initial begin
    float_point_num x;
    rst_i = 1'b1; req0_valid_i = 0; req1_valid_i = 0; fpu_valid_i = 0; fpu_res_i = '0;
    req0_a_i = '0; req0_b_i = '0; req1_a_i = '0; req1_b_i = '0;
    cyc = 0; lat = 3; auto_pipe = 0; chk_on = 0;
    rsp_seen[0] = 0; rsp_seen[1] = 0;
    model_reset();
    do_reset(0);
    chk_on = 1;
    do_reset(0);

    // Single operation through a three-cycle pipeline.
    req0_valid_i = 1; req0_a_i = 32'h3F800000; req0_b_i = 32'h40000000;
    cycle(); check_eq("single_grant", 32'(s_r0), 32'd1);
    req0_valid_i = 0;
    cycle(); check_eq("single_issue", 32'(s_fv), 32'd1);
    cycle(); cycle();
    fpu_valid_i = 1; fpu_res_i = 32'h40400000;
    cycle();
    cycle();
    check_eq("single_rsp0", 32'(s_rsp0), 32'd1);
    check_eq("single_res0", s_res0, 32'h40400000);
    check_eq("single_rsp1", 32'(s_rsp1), 32'd0);

    // Contention: alternate grants starting with req0.
    do_reset(0); auto_pipe = 1; lat = 3;
    rsp_seen[0] = 0; rsp_seen[1] = 0;
    for (int i = 0; i < 6; i++) begin
      req0_valid_i = 1; req1_valid_i = 1; rand_ops();
      cycle();
      check_eq("cont_grant0", 32'(s_r0), 32'(i % 2 == 0));
      check_eq("cont_grant1", 32'(s_r1), 32'(i % 2 == 1));
    end
    req0_valid_i = 0; req1_valid_i = 0;
    for (int i = 0; i < 10; i++) cycle();
    check_eq("cont_rsp0_count", 32'(rsp_seen[0]), 32'd3);
    check_eq("cont_rsp1_count", 32'(rsp_seen[1]), 32'd3);

    // Credit limit on req0.
    do_reset(0); auto_pipe = 0;
    req0_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      rand_ops(); cycle();
      check_eq("credit_fill", 32'(s_r0), 32'd1);
    end
    req1_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      rand_ops(); cycle();
      check_eq("credit_blk0", 32'(s_r0), 32'd0);
      check_eq("credit_req1", 32'(s_r1), 32'd1);
    end
    req1_valid_i = 0;
    fpu_valid_i = 1; fpu_res_i = float_point_num'($urandom());
    cycle(); check_eq("credit_ret", 32'(s_r0), 32'd0);
    cycle(); check_eq("credit_rsp0", 32'(s_rsp0), 32'd1);
    check_eq("credit_still0", 32'(s_r0), 32'd0);
    cycle(); check_eq("credit_reopen", 32'(s_r0), 32'd1);
    req0_valid_i = 0;

    // Simultaneous push/pop on an empty FIFO.
    do_reset(0);
    x = float_point_num'($urandom());
    req1_valid_i = 1; rand_ops(); fpu_valid_i = 1; fpu_res_i = x;
    cycle(); check_eq("byp_grant", 32'(s_r1), 32'd1);
    req1_valid_i = 0;
    check_eq("byp_count", 32'(dut.u_tag_fifo.count_q), 32'd0);
    cycle();
    check_eq("byp_rsp1", 32'(s_rsp1), 32'd1);
    check_eq("byp_res1", s_res1, x);
    check_eq("byp_rsp0", 32'(s_rsp0), 32'd0);
    check_eq("byp_err", 32'(s_err), 32'd0);

    // Spurious result.
    do_reset(0);
    fpu_valid_i = 1; fpu_res_i = float_point_num'($urandom());
    cycle(); check_eq("spur_err_pre", 32'(s_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("spur_err", 32'(s_err), 32'd1);
      check_eq("spur_rsp", 32'({s_rsp1, s_rsp0}), 32'd0);
    end
    do_reset(0);
    cycle(); check_eq("spur_clear", 32'(s_err), 32'd0);

    // Reset with three operations in flight.
    do_reset(0); auto_pipe = 1; lat = 3;
    for (int i = 0; i < 3; i++) begin
      req0_valid_i = 1; req1_valid_i = 1; rand_ops(); cycle();
    end
    req0_valid_i = 0; req1_valid_i = 0;
    rst_i = 1; cycle(); rst_i = 0;
    cycle();
    check_eq("mid_fv", 32'(s_fv), 32'd0);
    check_eq("mid_rsp", 32'({s_rsp1, s_rsp0}), 32'd0);
    check_eq("mid_err", 32'(s_err), 32'd0);
    for (int i = 0; i < 4; i++) cycle();
    check_eq("mid_late_err", 32'(s_err), 32'd1);
    req0_valid_i = 1; req1_valid_i = 1; rand_ops();
    cycle();
    check_eq("mid_first0", 32'(s_r0), 32'd1);
    check_eq("mid_first1", 32'(s_r1), 32'd0);

    // Randomised traffic at several pipeline latencies.
    do_reset(0); auto_pipe = 1;
    for (int ph = 0; ph < 3; ph++) begin
      lat = (ph == 0) ? 1 : (ph == 1) ? 2 : 5;
      for (int i = 0; i < 400; i++) begin
        req0_valid_i = ($urandom_range(0, 99) < 70);
        req1_valid_i = ($urandom_range(0, 99) < 60);
        rand_ops();
        cycle();
      end
      req0_valid_i = 0; req1_valid_i = 0;
      for (int i = 0; i < 12; i++) cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_add_arbiter.md
FPU_ADD_ARBITER -- requirements
Module: fpu_add_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUT, default 4: maximum in-flight operations per requester, range 1..8.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have ports req0_valid_i and req1_valid_i, input, 1 bit each: requester n has an operand pair.
REQ-005 SHALL have ports req0_ready_o and req1_ready_o, output, 1 bit each: requester n is granted this cycle.
REQ-006 SHALL have ports req0_a_i, req0_b_i, req1_a_i and req1_b_i, input, float_point_num (32 bits) each: operands.
REQ-007 SHALL have port fpu_valid_o, output, 1 bit: issue strobe to the shared FP add pipeline.
REQ-008 SHALL have ports fpu_a_o and fpu_b_o, output, float_point_num each: issued operands.
REQ-009 SHALL have port fpu_valid_i, input, 1 bit: the pipeline returns a result; in-order, never stalls.
REQ-010 SHALL have port fpu_res_i, input, float_point_num: pipeline result.
REQ-011 SHALL have ports rsp0_valid_o and rsp1_valid_o, output, 1 bit each: result for requester n, one-cycle pulse.
REQ-012 SHALL have ports rsp0_res_o and rsp1_res_o, output, float_point_num each: result data.
REQ-013 SHALL have port err_o, output, 1 bit: sticky flag, result received with no pending tag.

Function
REQ-014 SHALL grant at most one requester per cycle; handshake = reqN_valid_i & reqN_ready_o.
REQ-015 SHALL drive reqN_ready_o combinationally.
  - Condition: reqN_valid_i & outstanding_N < MAX_OUT & round-robin winner.
  - Round-robin: the requester not granted last has priority when both are eligible.
  - A sole eligible requester always wins.
REQ-016 SHALL register the issue: handshake in cycle N -> fpu_valid_o=1 in cycle N+1, with the granted operands on fpu_a_o/fpu_b_o.
REQ-017 SHALL hold fpu_valid_o=0 and fpu_a_o/fpu_b_o at their last value when no handshake occurs.
REQ-018 SHALL push the 1-bit requester tag into the tag FIFO on every handshake.
REQ-019 SHALL pop the tag FIFO when fpu_valid_i=1, and route the result as follows:
  - Registered: fpu_valid_i in cycle M -> rspT_valid_o=1 in cycle M+1.
  - rspT_res_o = fpu_res_i captured in cycle M.
  - The other response channel stays 0.
REQ-020 SHALL handle fpu_valid_i=1 with an empty tag FIFO by:
  - emitting no response;
  - leaving the FIFO unchanged;
  - setting err_o=1 until reset.
REQ-021 SHALL track outstanding_N (width clog2(MAX_OUT+1)) as follows:
  - +1 on requester N handshake.
  - -1 when rspN_valid_o is asserted.
  - Both in the same cycle -> unchanged.
REQ-022 SHALL size the tag FIFO at 2*MAX_OUT so that it never overflows by construction.
REQ-023 SHALL support push and pop in the same cycle, including when the FIFO is empty. In that case the pop returns the tag being pushed (bypass).
REQ-024 SHALL NOT alter the operands; all arithmetic is done by the external pipeline.

Reset
REQ-025 SHALL, while rst_i=1, clear all of the following on the next edge:
  - fpu_valid_o, rsp*_valid_o, err_o;
  - outstanding counters, FIFO pointers and count;
  - round-robin pointer (req0 priority first);
  - fpu_*_o and rsp*_res_o data.
REQ-026 SHALL force req*_ready_o=0 while rst_i=1.
REQ-027 SHALL discard in-flight tags on reset mid-operation. Results arriving after reset then raise err_o.

Structure
REQ-028 SHALL take float_point_num from float_types_pkg. The package SHALL also hold the tag typedef (fpu_req_tag_t, 1 bit) and the localparam FPU_REQ_NUM=2.
REQ-029 SHALL instantiate exactly one sub-module, fpu_tag_fifo: a synchronous FIFO parameterised by depth, with push, pop, empty, full and bypass.

Verification
REQ-030 Single op:
  - Stimulus: req0, a=0x3F800000, b=0x40000000; pipeline returns 0x40400000 three cycles after issue.
  - Response: fpu_valid_o one cycle after handshake; rsp0_valid_o one cycle after fpu_valid_i with 0x40400000; rsp1_valid_o stays 0.
REQ-031 Contention:
  - Stimulus: both requesters valid continuously for 6 cycles.
  - Response: grants alternate 0,1,0,1,0,1; responses are routed to the matching requester in order.
REQ-032 Credit limit (MAX_OUT=4):
  - Stimulus: req0 issues 4 ops with no results returned.
  - Response: req0_ready_o=0 from then on, while req1 is still granted. One returned result re-enables req0 the cycle after rsp0_valid_o.
REQ-033 Simultaneous push/pop:
  - Stimulus: FIFO empty, handshake and fpu_valid_i in the same cycle.
  - Response: routing is correct via bypass; FIFO count stays 0.
REQ-034 Spurious result:
  - Stimulus: fpu_valid_i=1 with nothing outstanding.
  - Response: err_o=1 next cycle and held; no rsp pulse; rst_i clears err_o.
REQ-035 Reset mid-flight:
  - Stimulus: rst_i asserted with 3 ops pending.
  - Response: all outputs 0 after one edge; the next grant goes to req0.
